// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uartTX among N_REQ byte producers.
// Each grant moves one byte, issues one send pulse and tracks the busy handshake.
module uart_tx_arbiter #(
  parameter int N_REQ         = 4,
  parameter int DATA_W        = 8,
  parameter int START_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_send,
  input  logic                       tx_busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       active,
  output logic                       tx_done,
  output logic                       timeout_err
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    last_grant, last_grant_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  logic [N_REQ-1:0]   req_ready_nxt;
  logic [DATA_W-1:0]  tx_data_nxt;
  logic               tx_send_nxt;
  logic [ID_W-1:0]    grant_id_nxt;
  logic               tx_done_nxt;
  logic               timeout_err_nxt;

  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [DATA_W-1:0]  win_data;

  // Requester index reached by stepping 'off' places past 'base', wrapping at N_REQ.
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
    return ID_W'((int'(base) + off) % N_REQ);
  endfunction

  // Search starts just after the last winner, so the previous winner has lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!win_found && req_valid[rr_idx(last_grant, k)]) begin
        win_found = 1'b1;
        win_id    = rr_idx(last_grant, k);
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_id == ID_W'(k)) begin
        win_data = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    last_grant_nxt  = last_grant;
    cnt_nxt         = cnt;
    tx_data_nxt     = tx_data;
    grant_id_nxt    = grant_id;
    req_ready_nxt   = '0;
    tx_send_nxt     = 1'b0;
    tx_done_nxt     = 1'b0;
    timeout_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (win_found && !tx_busy) begin
          tx_data_nxt           = win_data;
          req_ready_nxt[win_id] = 1'b1;
          grant_id_nxt          = win_id;
          last_grant_nxt        = win_id;
          state_nxt             = ISSUE;
        end
      end
      ISSUE: begin
        tx_send_nxt = 1'b1;
        cnt_nxt     = '0;
        state_nxt   = WAIT_START;
      end
      WAIT_START: begin
        // A transmitter that never starts drops the byte rather than retrying it.
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == CNT_MAX) begin
          timeout_err_nxt = 1'b1;
          state_nxt       = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          tx_done_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= LAST_RST;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
    end
  end

  // Outputs are registered copies of the next-state decode; active mirrors the new state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready   <= '0;
      tx_data     <= '0;
      tx_send     <= 1'b0;
      grant_id    <= '0;
      active      <= 1'b0;
      tx_done     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      req_ready   <= req_ready_nxt;
      tx_data     <= tx_data_nxt;
      tx_send     <= tx_send_nxt;
      grant_id    <= grant_id_nxt;
      active      <= (state_nxt != IDLE);
      tx_done     <= tx_done_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

endmodule
